// File: rtl/fp_div_d_seq.sv
// Multicycle sequencer around a combinational binary64 divider.
// Registers operands onto the divider, waits LATENCY cycles, captures the
// quotient with RISC-V fflags and hands it to writeback over valid/ready.
// Optional: define FP_DIV_D_SEQ_FASTSPECIAL_EN to finish NaN/inf/zero
// operand pairs after a single wait cycle.
module fp_div_d_seq #(
  parameter int LATENCY = 4,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [63:0]      div_a,
  output logic [63:0]      div_b,
  input  logic [63:0]      div_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [4:0]       out_fflags,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "fp_div_d_seq: LATENCY must be in 1..15");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam logic [10:0] EXP_MAX = 11'h7FF;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [63:0]      div_a_q, div_a_d;
  logic [63:0]      div_b_q, div_b_d;
  logic [63:0]      res_q, res_d;
  logic [4:0]       flags_q, flags_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // Field extraction for flag derivation
  logic [10:0] a_exp, b_exp, q_exp;
  logic [51:0] a_frac, b_frac, q_frac;
  logic        unused_q_sign;

  assign a_exp  = div_a_q[62:52];
  assign a_frac = div_a_q[51:0];
  assign b_exp  = div_b_q[62:52];
  assign b_frac = div_b_q[51:0];
  assign q_exp  = div_result[62:52];
  assign q_frac = div_result[51:0];
  assign unused_q_sign = div_result[63];

  logic a_zero, a_inf, a_nan, a_snan, a_fin;
  logic b_zero, b_inf, b_nan, b_snan, b_fin;
  logic q_zero;

  assign a_zero = (a_exp == 11'd0) && (a_frac == 52'd0);
  assign a_inf  = (a_exp == EXP_MAX) && (a_frac == 52'd0);
  assign a_nan  = (a_exp == EXP_MAX) && (a_frac != 52'd0);
  assign a_snan = a_nan && !a_frac[51];
  assign a_fin  = (a_exp != EXP_MAX);

  assign b_zero = (b_exp == 11'd0) && (b_frac == 52'd0);
  assign b_inf  = (b_exp == EXP_MAX) && (b_frac == 52'd0);
  assign b_nan  = (b_exp == EXP_MAX) && (b_frac != 52'd0);
  assign b_snan = b_nan && !b_frac[51];
  assign b_fin  = (b_exp != EXP_MAX);

  assign q_zero = (q_exp == 11'd0) && (q_frac == 52'd0);

  logic flag_nv, flag_dz, flag_of, flag_uf;
  logic [4:0] fflags_c;

  // Inexact is only reported for overflow/underflow; truncation is not detected
  assign flag_nv  = a_snan || b_snan || (a_zero && b_zero) || (a_inf && b_inf);
  assign flag_dz  = b_zero && a_fin && !a_zero;
  assign flag_of  = a_fin && b_fin && !b_zero && (q_exp == EXP_MAX);
  assign flag_uf  = a_fin && !a_zero && b_fin && !b_zero && q_zero;
  assign fflags_c = {flag_nv, flag_dz, flag_of, flag_uf, flag_of | flag_uf};

`ifdef FP_DIV_D_SEQ_FASTSPECIAL_EN
  // NaN, infinity or zero operands make the quotient trivial for the divider
  logic in_special;
  assign in_special = (in_a[62:52] == EXP_MAX) || (in_a[62:0] == 63'd0) ||
                      (in_b[62:52] == EXP_MAX) || (in_b[62:0] == 63'd0);
`endif

  assign in_ready = (state_q == ST_IDLE) && !flush;

  // Next-state: accept in IDLE, count down in BUSY, hand off in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    res_d   = res_q;
    flags_d = flags_q;
    tag_d   = tag_q;
    if (flush) begin
      // Kill control only; data registers keep their last contents
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_d = ST_BUSY;
            div_a_d = in_a;
            div_b_d = in_b;
            tag_d   = in_tag;
`ifdef FP_DIV_D_SEQ_FASTSPECIAL_EN
            cnt_d   = in_special ? 4'd0 : CNT_INIT;
`else
            cnt_d   = CNT_INIT;
`endif
          end
        end
        ST_BUSY: begin
          if (cnt_q == 4'd0) begin
            res_d   = div_result;
            flags_d = fflags_c;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      div_a_q <= 64'd0;
      div_b_q <= 64'd0;
      res_q   <= 64'd0;
      flags_q <= 5'd0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      tag_q   <= tag_d;
    end
  end

  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = res_q;
  assign out_fflags = flags_q;
  assign out_tag    = tag_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
